// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: table entry layout, FSM
// states, the reset value of a table entry and the counter-load helper.
package pulse_seq_pkg;

  // Field widths of a table entry. A sequencer instance must use
  // $clog2(NumChannels) <= ChW and CntWidth == CntW.
  localparam int unsigned ChW  = 3;
  localparam int unsigned CntW = 16;

  typedef struct packed {
    logic [ChW-1:0]  ch;
    logic [CntW-1:0] high;
    logic [CntW-1:0] gap;
  } seq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } seq_state_e;

  localparam seq_entry_t SeqEntryDefault = '{ch: '0, high: '0, gap: '0};

  // Down-counter load value for a phase lasting max(t,1) cycles.
  function automatic logic [CntW-1:0] load_cnt(input logic [CntW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/pulse_seq_table.sv
// Sequence table storage: Depth entries held in flops, one write port,
// combinational read port, cleared by reset.
//   clk_i, rst_ni : clock, async active-low reset
//   we_i          : write strobe (gated by the caller while busy)
//   waddr_i       : write index, out-of-range indices are dropped
//   wdata_i       : entry to write
//   raddr_i       : read index
//   rdata_o       : entry at raddr_i
module pulse_seq_table
  import pulse_seq_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  seq_entry_t               wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output seq_entry_t               rdata_o
);

  seq_entry_t mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= SeqEntryDefault;
    end else if (we_i && (32'(waddr_i) < Depth)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays table entries {ch, high, gap} in order, once or
// looping, driving a one-hot pulse vector.
//   clk_i, rst_ni         : clock, async active-low reset
//   start_i / stop_i      : single-cycle start / abort (stop wins)
//   loop_i, len_i         : repeat flag and entry count, sampled on start
//   tbl_we_i/addr/wdata   : table write port, honoured only while idle
//   busy_o                : sequence active
//   done_o                : one-cycle pulse at end of a non-looping run
//   cur_idx_o             : index of the executing entry
//   pulse_o               : registered one-hot (or zero) pulse outputs
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned Depth       = 8,
  parameter int unsigned CntWidth    = CntW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  input  logic [$clog2(Depth):0]   len_i,
  input  logic                     tbl_we_i,
  input  logic [$clog2(Depth)-1:0] tbl_addr_i,
  input  seq_entry_t               tbl_wdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(Depth)-1:0] cur_idx_o,
  output logic [NumChannels-1:0]   pulse_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthLen = LW'(Depth);

  seq_state_e            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  loop_q, loop_d;
  logic [ChW-1:0]        ch_q, ch_d;
  logic [CntW-1:0]       gap_q, gap_d;
  logic                  done_q, done_d;
  logic [NumChannels-1:0] pulse_q, pulse_d;

  logic          last, load;
  logic [AW-1:0] rd_idx;
  logic [LW-1:0] len_clamped;
  seq_entry_t    rd_entry;

  assign len_clamped = (len_i > DepthLen) ? DepthLen : len_i;
  assign last        = (LW'(idx_q) + LW'(1)) >= len_q;
  // Single read port: always points at the entry the next load would take
  // (first entry on start, successor or wrap-around on advance). The
  // current entry's ch/gap are latched at load time.
  assign rd_idx      = ((state_q == IDLE) || last) ? '0 : idx_q + AW'(1);

  pulse_seq_table #(.Depth(Depth)) u_table (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (tbl_we_i && (state_q == IDLE)),
    .waddr_i (tbl_addr_i),
    .wdata_i (tbl_wdata_i),
    .raddr_i (rd_idx),
    .rdata_o (rd_entry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    loop_d  = loop_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            len_d  = len_clamped;
            loop_d = loop_i;
            idx_d  = '0;
            load   = 1'b1;
          end
        end
      end
      HIGH, GAP: begin
        if (stop_i) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((state_q == HIGH) && (gap_q != '0)) begin
          state_d = GAP;
          cnt_d   = load_cnt(gap_q);
        end else if (!last) begin
          idx_d = idx_q + AW'(1);
          load  = 1'b1;
        end else if (loop_q) begin
          idx_d = '0;
          load  = 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = HIGH;
      cnt_d   = load_cnt(rd_entry.high);
      ch_d    = rd_entry.ch;
      gap_d   = rd_entry.gap;
    end
    // Derived from next state so back-to-back entries on one channel stay
    // continuously high; out-of-range channels run their timing silently.
    pulse_d = '0;
    if ((state_d == HIGH) && (32'(ch_d) < NumChannels)) begin
      pulse_d = NumChannels'(1) << ch_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      ch_q    <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign cur_idx_o = idx_q;
  assign pulse_o   = pulse_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer (NumChannels=6 so that out-of-range channels
// can be exercised). A per-cycle expected-output trace is built from a
// bench copy of the table and compared every cycle; literal checks pin
// key cycles by hand.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

  localparam int NCH = 6;
  localparam int DEP = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, loop = 1'b0, we = 1'b0;
  logic [3:0]       len = '0;
  logic [2:0]       addr = '0;
  seq_entry_t       wdata = '0;
  logic             busy, done;
  logic [2:0]       cur_idx;
  logic [NCH-1:0]   pulse;

  pulse_sequencer #(.NumChannels(NCH), .Depth(DEP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .loop_i      (loop),
    .len_i       (len),
    .tbl_we_i    (we),
    .tbl_addr_i  (addr),
    .tbl_wdata_i (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .cur_idx_o   (cur_idx),
    .pulse_o     (pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] pls;
    logic           bsy;
    logic           dn;
    logic [2:0]     ix;
  } exp_t;

  exp_t       q[$];
  seq_entry_t tbl_m [DEP];
  int         tests = 0;
  int         fails = 0;

  function automatic logic [NCH-1:0] oh(input logic [2:0] ch);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (c == int'(ch));
    return r;
  endfunction

  function automatic bit m_busy();
    return (q.size() > 0) && q[0].bsy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected trace of one run: max(high,1) cycles on ch, gap cycles low,
  // then a done cycle unless looping. Element 0 covers the start cycle.
  task automatic push_run(input int n, input bit lp, input int passes);
    if (q.size() == 0) q.push_back('0);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) begin
        int h = (tbl_m[i].high == 0) ? 1 : int'(tbl_m[i].high);
        for (int k = 0; k < h; k++)
          q.push_back('{pls: oh(tbl_m[i].ch), bsy: 1'b1, dn: 1'b0, ix: 3'(i)});
        for (int k = 0; k < int'(tbl_m[i].gap); k++)
          q.push_back('{pls: '0, bsy: 1'b1, dn: 1'b0, ix: 3'(i)});
      end
    if (!lp) q.push_back('{pls: '0, bsy: 1'b0, dn: 1'b1, ix: 3'd0});
  endtask

  task automatic wr(input int a, input int ch, input int h, input int g);
    we    = 1'b1;
    addr  = 3'(a);
    wdata = '{ch: 3'(ch), high: 16'(h), gap: 16'(g)};
    if (!m_busy()) tbl_m[a] = wdata;
    tick();
    we = 1'b0;
  endtask

  task automatic go(input logic [3:0] l, input bit lp, input bit also_stop);
    int n = (l > DEP) ? DEP : int'(l);
    start = 1'b1; len = l; loop = lp; stop = also_stop;
    if (!also_stop && !m_busy()) push_run(n, lp, lp ? 3 : 1);
    tick();
    start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    while (q.size() > 1) void'(q.pop_back());
    tick();
    stop = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst_n) begin
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      tests++;
      if (pulse !== e.pls || busy !== e.bsy || done !== e.dn || (e.bsy && cur_idx !== e.ix)) begin
        fails++;
        $display("FAIL cycle@%0t: got pulse=%b busy=%b done=%b idx=%0d want pulse=%b busy=%b done=%b idx=%0d",
                 $time, pulse, busy, done, cur_idx, e.pls, e.bsy, e.dn, e.ix);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEP; i++) tbl_m[i] = '0;
    tick(); tick();
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(cur_idx), 0);
    rst_n = 1'b1;
    tick();

    // two entries, single pass
    wr(0, 3, 4, 2); wr(1, 5, 1, 0);
    go(2, 0, 0);                              // t+1
    chk("seq_t1_ch3", 32'(pulse), 32'h08);
    repeat (4) tick();                        // t+5
    chk("seq_t5_gap", 32'(pulse), 0);
    repeat (2) tick();                        // t+7
    chk("seq_t7_ch5", 32'(pulse), 32'h20);
    tick();                                   // t+8
    chk("seq_t8_done", 32'(done), 1);
    chk("seq_t8_busy", 32'(busy), 0);
    drain();

    // looping, stopped in the second pass
    go(2, 1, 0);                              // t+1
    repeat (7) tick();                        // t+8: second pass begins
    chk("loop_t8_ch3", 32'(pulse), 32'h08);
    chk("loop_t8_idx", 32'(cur_idx), 0);
    repeat (2) tick();
    do_stop();
    chk("stop_pulse", 32'(pulse), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_nodone", 32'(done), 0);
    drain();

    // same channel back-to-back stays high
    wr(0, 2, 3, 0); wr(1, 2, 2, 0);
    go(2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("same_ch_high", 32'(pulse), 32'h04);
      tick();
    end
    chk("same_ch_done", 32'(done), 1);
    drain();

    // len 0
    go(0, 0, 0);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    drain();

    // channel beyond NumChannels: silent, timing kept
    wr(0, 7, 3, 2);
    go(1, 0, 0);
    repeat (5) tick();                        // t+6
    chk("ch7_done", 32'(done), 1);
    drain();

    // high 0 acts as 1
    wr(0, 1, 0, 0);
    go(1, 0, 0);
    chk("h0_pulse", 32'(pulse), 32'h02);
    tick();
    chk("h0_done", 32'(done), 1);
    drain();

    // write while busy is dropped
    wr(0, 4, 2, 0);
    go(1, 0, 0);
    wr(0, 1, 5, 5);
    drain();
    go(1, 0, 0);
    chk("busy_wr_kept", 32'(pulse), 32'h10);
    drain();

    // start and stop together in idle
    go(1, 0, 1);
    chk("startstop_busy", 32'(busy), 0);
    chk("startstop_done", 32'(done), 0);
    drain();

    // start while busy ignored
    wr(0, 3, 4, 0);
    go(1, 0, 0);
    go(1, 0, 0);
    drain();

    // len above Depth clamps to Depth
    for (int i = 0; i < DEP; i++) wr(i, i % 6, 1 + i % 2, i % 3);
    go(4'd15, 0, 0);
    drain();

    // start on the done cycle
    wr(0, 2, 1, 0);
    go(1, 0, 0);                              // t+1
    tick();                                   // t+2
    chk("redo_done", 32'(done), 1);
    go(1, 0, 0);                              // t+3
    chk("redo_pulse", 32'(pulse), 32'h04);
    drain();

    // reset in HIGH of entry 1
    wr(0, 3, 4, 2); wr(1, 5, 3, 0);
    go(2, 0, 0);
    repeat (7) tick();                        // t+8
    chk("mid_idx1", 32'(cur_idx), 1);
    rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < DEP; i++) tbl_m[i] = '0;
    #1;
    chk("arst_pulse", 32'(pulse), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(cur_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    go(1, 0, 0);
    chk("zero_tbl_ch0", 32'(pulse), 32'h01);
    tick();
    chk("zero_tbl_done", 32'(done), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
